// File: rtl/cpi_pkg.sv
// cpi_pkg: shared definitions for the CPI multiply/divide coprocessor.
//   - subop encodings (inst[27:24])
//   - default claimed major opcode
//   - fixed end-to-end latency of a legal operation
//   - FSM state encoding
package cpi_pkg;

  localparam logic [3:0] CP_OP_DEFAULT = 4'h6;

  localparam logic [3:0] SUB_MUL   = 4'd0;
  localparam logic [3:0] SUB_MULH  = 4'd1;
  localparam logic [3:0] SUB_MULHU = 4'd2;
  localparam logic [3:0] SUB_DIV   = 4'd3;
  localparam logic [3:0] SUB_DIVU  = 4'd4;
  localparam logic [3:0] SUB_REM   = 4'd5;
  localparam logic [3:0] SUB_REMU  = 4'd6;

  // cpi_ready lands this many cycles after the accepting cycle
  localparam int MULDIV_LAT = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic sub_legal(input logic [3:0] s);
    return s <= SUB_REMU;
  endfunction

  function automatic logic sub_is_div(input logic [3:0] s);
    return (s == SUB_DIV) || (s == SUB_DIVU) || (s == SUB_REM) || (s == SUB_REMU);
  endfunction

  function automatic logic sub_is_signed(input logic [3:0] s);
    return (s == SUB_MULH) || (s == SUB_DIV) || (s == SUB_REM);
  endfunction

endpackage

// File: rtl/cpi_muldiv_if.sv
// cpi_muldiv_if: CPU <-> coprocessor (CPI) port.
//   master = CPU side: drives cpi_valid/cpi_inst/cpi_r1/cpi_r2
//   slave  = coprocessor side: drives cpi_ready/cpi_wait/cpi_data/cpi_drop
interface cpi_muldiv_if;
  logic        cpi_valid;
  logic [31:0] cpi_inst;
  logic [31:0] cpi_r1;
  logic [31:0] cpi_r2;
  logic        cpi_ready;
  logic        cpi_wait;
  logic [31:0] cpi_data;
  logic        cpi_drop;

  modport master (
    output cpi_valid, cpi_inst, cpi_r1, cpi_r2,
    input  cpi_ready, cpi_wait, cpi_data, cpi_drop
  );

  modport slave (
    input  cpi_valid, cpi_inst, cpi_r1, cpi_r2,
    output cpi_ready, cpi_wait, cpi_data, cpi_drop
  );
endinterface

// File: rtl/cpi_muldiv_iter.sv
// muldiv_iter: radix-2 iterative unsigned multiply / restoring divide engine.
//   clk, rst   clock, synchronous active-high reset
//   start_i    load operands, counter=31
//   step_i     perform one radix-2 step
//   div_i      1 = divide, 0 = multiply (sampled on start_i)
//   a_i, b_i   unsigned operands (multiplicand/multiplier or dividend/divisor)
//   acc_o      multiply: 64-bit product; divide: {remainder, quotient}
//   done_o     counter at 0: the current step is the last one
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o,
  output logic        done_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;

  logic [32:0] mul_sum;
  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;

    // multiply: low half holds the multiplier bits still to consume
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // divide: partial remainder shifted left with the next dividend bit
    trial   = acc_q[63:31];
    diff    = trial - {1'b0, opnd_q};

    if (start_i) begin
      div_d  = div_i;
      opnd_d = div_i ? b_i : a_i;
      acc_d  = div_i ? {32'd0, a_i} : {32'd0, b_i};
      cnt_d  = 5'd31;
    end else if (step_i) begin
      if (div_q) begin
        // diff[32] set means trial < divisor: restore
        acc_d = diff[32] ? {trial[31:0], acc_q[30:0], 1'b0}
                         : {diff[31:0],  acc_q[30:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[31:1]};
      end
      if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = (cnt_q == 5'd0);

endmodule

// File: rtl/cpi_muldiv.sv
// cpi_muldiv: multiply/divide coprocessor on the CPI port.
//   clk, rst   clock, synchronous active-high reset
//   cpi        slave side of cpi_muldiv_if (request in, registered response out)
// Claims inst[31:28]==CP_OP; subop inst[27:24]. Legal ops answer at t0+34.
//
//   state | meaning
//   IDLE  | waiting for a claimed request (ignores valid one cycle after DONE)
//   BUSY  | 32 radix-2 steps in muldiv_iter
//   FIX   | sign correction and result select
//   DONE  | cpi_ready strobe (drop=1 legal, drop=0 illegal subop)
module cpi_muldiv
  import cpi_pkg::*;
#(
  parameter logic [3:0] CP_OP = CP_OP_DEFAULT,
  parameter int         XLEN  = 32
) (
  input logic           clk,
  input logic           rst,
  cpi_muldiv_if.slave   cpi
);

  state_t            state_q, state_d;
  logic [3:0]        sub_q, sub_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   araw_q, araw_d;
  logic              guard_q, guard_d;
  logic              ready_q, ready_d;
  logic              wait_q, wait_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic              it_start, it_step, it_done;
  logic [2*XLEN-1:0] acc;

  logic [3:0]        in_sub;
  logic              in_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res;

  always_comb begin
    in_sub = cpi.cpi_inst[27:24];
    in_sgn = sub_is_signed(in_sub);
    a_neg  = in_sgn & cpi.cpi_r1[XLEN-1];
    b_neg  = in_sgn & cpi.cpi_r2[XLEN-1];
    a_mag  = a_neg ? (XLEN'(0) - cpi.cpi_r1) : cpi.cpi_r1;
    b_mag  = b_neg ? (XLEN'(0) - cpi.cpi_r2) : cpi.cpi_r2;
  end

  // Divide by zero skips sign fix: quotient all ones, remainder is raw A.
  always_comb begin
    prod = (sa_q ^ sb_q) ? ((2*XLEN)'(0) - acc) : acc;
    res  = '0;
    case (sub_q)
      SUB_MUL:             res = prod[XLEN-1:0];
      SUB_MULH, SUB_MULHU: res = prod[2*XLEN-1:XLEN];
      SUB_DIV, SUB_DIVU:
        res = div0_q ? '1
            : ((sa_q ^ sb_q) ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0]);
      SUB_REM, SUB_REMU:
        res = div0_q ? araw_q
            : (sa_q ? (XLEN'(0) - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN]);
      default:             res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    araw_d   = araw_q;
    guard_d  = 1'b0;
    ready_d  = 1'b0;
    wait_d   = 1'b0;
    drop_d   = 1'b0;
    data_d   = '0;
    it_start = 1'b0;
    it_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!guard_q && cpi.cpi_valid && cpi.cpi_inst[31:28] == CP_OP) begin
          if (sub_legal(in_sub)) begin
            it_start = 1'b1;
            sub_d    = in_sub;
            sa_d     = a_neg;
            sb_d     = b_neg;
            div0_d   = (cpi.cpi_r2 == '0);
            araw_d   = cpi.cpi_r1;
            wait_d   = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            ready_d  = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (!cpi.cpi_valid) begin
          state_d = ST_IDLE;
        end else begin
          it_step = 1'b1;
          wait_d  = 1'b1;
          if (it_done) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!cpi.cpi_valid) begin
          state_d = ST_IDLE;
        end else begin
          ready_d = 1'b1;
          drop_d  = 1'b1;
          data_d  = res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // CPU drops valid one cycle after seeing ready; skip that cycle
        guard_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sub_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      araw_q  <= '0;
      guard_q <= 1'b0;
      ready_q <= 1'b0;
      wait_q  <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      araw_q  <= araw_d;
      guard_q <= guard_d;
      ready_q <= ready_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
    end
  end

  muldiv_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (it_start),
    .step_i  (it_step),
    .div_i   (sub_is_div(in_sub)),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .acc_o   (acc),
    .done_o  (it_done)
  );

  assign cpi.cpi_ready = ready_q;
  assign cpi.cpi_wait  = wait_q;
  assign cpi.cpi_data  = data_q;
  assign cpi.cpi_drop  = drop_q;

endmodule

// File: tb/tb_cpi_muldiv.sv
// tb_cpi_muldiv: directed vector table plus hand-written multi-cycle sequences
// (unclaimed opcode, abort in BUSY and FIX, reset mid-operation).
module tb_cpi_muldiv;
  import cpi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpi_muldiv_if bus ();

  cpi_muldiv #(.CP_OP(CP_OP_DEFAULT), .XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .cpi (bus)
  );

  typedef struct {
    logic [3:0]  sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        drop;
    int          lat;
  } vec_t;

  vec_t vecs[18];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Issue one request at cycle t0 and watch 40 cycles; valid is held through
  // t0+lat+1 to mimic the CPU's one-cycle-late deassertion.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] sub,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic drop, input int lat);
    int          first;
    int          nready;
    int          wait_bad;
    logic [31:0] got_data;
    logic        got_drop;
    logic        exp_wait;
    first = 0; nready = 0; wait_bad = 0; got_data = '0; got_drop = 1'b0;
    bus.cpi_inst  = {op, sub, 24'h0};
    bus.cpi_r1    = a;
    bus.cpi_r2    = b;
    bus.cpi_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.cpi_ready) begin
        nready++;
        if (first == 0) begin
          first    = k;
          got_data = bus.cpi_data;
          got_drop = bus.cpi_drop;
        end
      end
      exp_wait = (lat == MULDIV_LAT) && (k < lat);
      if (bus.cpi_wait !== exp_wait) wait_bad++;
      if (first != 0 && k == first + 2) bus.cpi_valid = 1'b0;
    end
    bus.cpi_valid = 1'b0;
    chk({tag, " latency"}, 32'(first), 32'(lat));
    chk({tag, " ready count"}, 32'(nready), 32'd1);
    if (drop) chk({tag, " data"}, got_data, exp);
    chk({tag, " drop"}, {31'd0, got_drop}, {31'd0, drop});
    chk({tag, " wait pattern errors"}, 32'(wait_bad), 32'd0);
  endtask

  initial begin
    int nready;
    int nwait;

    vecs[0]  = '{SUB_MUL,   32'd7,          32'd6,          32'd42,         1'b1, 34};
    vecs[1]  = '{SUB_MUL,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   1'b1, 34};
    vecs[2]  = '{SUB_MULH,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   1'b1, 34};
    vecs[3]  = '{SUB_MULHU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b1, 34};
    vecs[4]  = '{SUB_MULH,  32'h80000000,   32'd2,          32'hFFFFFFFF,   1'b1, 34};
    vecs[5]  = '{SUB_DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b1, 34};
    vecs[6]  = '{SUB_REM,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b1, 34};
    vecs[7]  = '{SUB_DIVU,  32'd100,        32'd7,          32'd14,         1'b1, 34};
    vecs[8]  = '{SUB_REMU,  32'd100,        32'd7,          32'd2,          1'b1, 34};
    vecs[9]  = '{SUB_DIV,   32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b1, 34};
    vecs[10] = '{SUB_REM,   32'd7,          32'hFFFFFFFE,   32'd1,          1'b1, 34};
    vecs[11] = '{SUB_DIV,   32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, 34};
    vecs[12] = '{SUB_REM,   32'd5,          32'd0,          32'd5,          1'b1, 34};
    vecs[13] = '{SUB_REM,   32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1'b1, 34};
    vecs[14] = '{SUB_DIVU,  32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, 34};
    vecs[15] = '{SUB_DIV,   32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, 34};
    vecs[16] = '{SUB_REM,   32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b1, 34};
    vecs[17] = '{4'd9,      32'd1,          32'd1,          32'h00000000,   1'b0, 1};

    bus.cpi_valid = 1'b0;
    bus.cpi_inst  = '0;
    bus.cpi_r1    = '0;
    bus.cpi_r2    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, bus.cpi_ready}, 32'd0);
    chk("reset wait",  {31'd0, bus.cpi_wait},  32'd0);
    chk("reset data",  bus.cpi_data,           32'd0);
    chk("reset drop",  {31'd0, bus.cpi_drop},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), CP_OP_DEFAULT, vecs[i].sub, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].drop, vecs[i].lat);
      repeat (2) @(posedge clk);
      #1;
    end

    // Unclaimed opcode: 20 cycles of valid with no response
    bus.cpi_inst  = {4'h5, SUB_MUL, 24'h0};
    bus.cpi_r1    = 32'd3;
    bus.cpi_r2    = 32'd4;
    bus.cpi_valid = 1'b1;
    nready = 0; nwait = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.cpi_ready) nready++;
      if (bus.cpi_wait)  nwait++;
    end
    bus.cpi_valid = 1'b0;
    chk("unclaimed ready cycles", 32'(nready), 32'd0);
    chk("unclaimed wait cycles",  32'(nwait),  32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Abort in BUSY: valid dropped during t0+5
    bus.cpi_inst  = {CP_OP_DEFAULT, SUB_DIVU, 24'h0};
    bus.cpi_r1    = 32'd100;
    bus.cpi_r2    = 32'd7;
    bus.cpi_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    chk("abort busy wait before", {31'd0, bus.cpi_wait}, 32'd1);
    bus.cpi_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort busy wait after", {31'd0, bus.cpi_wait}, 32'd0);
    nready = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.cpi_ready) nready++;
    end
    chk("abort busy ready", 32'(nready), 32'd0);

    // Abort in FIX: valid dropped during t0+33
    bus.cpi_inst  = {CP_OP_DEFAULT, SUB_MUL, 24'h0};
    bus.cpi_r1    = 32'd7;
    bus.cpi_r2    = 32'd6;
    bus.cpi_valid = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
    end
    bus.cpi_valid = 1'b0;
    nready = 0; nwait = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.cpi_ready) nready++;
      if (bus.cpi_wait)  nwait++;
    end
    chk("abort fix ready", 32'(nready), 32'd0);
    chk("abort fix wait",  32'(nwait),  32'd0);

    // Reset during t0+10, then a fresh operation
    bus.cpi_inst  = {CP_OP_DEFAULT, SUB_MUL, 24'h0};
    bus.cpi_r1    = 32'd9;
    bus.cpi_r2    = 32'd9;
    bus.cpi_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    chk("midrst wait before", {31'd0, bus.cpi_wait}, 32'd1);
    rst = 1'b1;
    bus.cpi_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst ready", {31'd0, bus.cpi_ready}, 32'd0);
    chk("midrst wait",  {31'd0, bus.cpi_wait},  32'd0);
    chk("midrst data",  bus.cpi_data,           32'd0);
    chk("midrst drop",  {31'd0, bus.cpi_drop},  32'd0);
    rst = 1'b0;
    nready = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.cpi_ready) nready++;
    end
    chk("midrst late ready", 32'(nready), 32'd0);
    run_op("after rst", CP_OP_DEFAULT, SUB_MUL, 32'd7, 32'd6, 32'd42, 1'b1, MULDIV_LAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
